// File: rtl/mem_responder.sv
// Word-addressed RAM responder: one request at a time, LATENCY wait states, one-cycle ack.
// Optional LED/switch MMIO window at 0xFFF0/0xFFF1 is compiled in with MEM_RESPONDER_MMIO_EN.
module mem_responder #(
    parameter int WIDTH    = 16,
    parameter int ADDRBITS = 10,
    parameter int LATENCY  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ack,
    output logic             busy,
    output logic             err,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] led_out,
    output logic [1:0]       state_dbg
);
    // Handshake: a request is accepted in any IDLE cycle with req high; the requester keeps
    // req/addr/we/wdata stable until ack and drops req in the ack cycle to avoid a repeat.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    localparam int         DEPTH    = 2 ** ADDRBITS;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]     addr_q, wdata_q, rdata_q, rdata_d, led_q, led_d;
    logic                 we_q;
    logic [WIDTH-1:0]     mem [DEPTH];

    logic [WIDTH-1:0]     eff_addr, eff_wdata;
    logic                 eff_we, accept, commit;
    logic                 eff_led, eff_sw, q_led, q_sw, sw_read;
    logic [ADDRBITS-1:0]  eff_idx;

    function automatic logic in_range(input logic [WIDTH-1:0] a);
        return (ADDRBITS >= WIDTH) || ((a >> ADDRBITS) == '0);
    endfunction

`ifdef MEM_RESPONDER_MMIO_EN
    localparam logic [WIDTH-1:0] LED_ADDR = WIDTH'(16'hFFF0);
    localparam logic [WIDTH-1:0] SW_ADDR  = WIDTH'(16'hFFF1);
    assign eff_led = (eff_addr == LED_ADDR);
    assign eff_sw  = (eff_addr == SW_ADDR);
    assign q_led   = (addr_q == LED_ADDR);
    assign q_sw    = (addr_q == SW_ADDR);
`else
    assign eff_led = 1'b0;
    assign eff_sw  = 1'b0;
    assign q_led   = 1'b0;
    assign q_sw    = 1'b0;
`endif

    // With LATENCY = 0 the commit edge is also the acceptance edge, so use live inputs in IDLE.
    always_comb begin
        eff_addr  = addr_q;
        eff_we    = we_q;
        eff_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            eff_addr  = addr;
            eff_we    = we;
            eff_wdata = wdata;
        end
    end

    assign eff_idx = eff_addr[ADDRBITS-1:0];
    assign accept  = (state_q == S_IDLE) && req;
    assign commit  = (state_d == S_RESP);
    assign sw_read = (state_q == S_RESP) && q_sw && !we_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            if (accept) begin
                addr_q  <= addr;
                we_q    <= we;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        led_d   = led_q;
        if (commit) begin
            if (eff_led) begin
                rdata_d = eff_we ? eff_wdata : led_q;
                if (eff_we) led_d = eff_wdata;
            end else if (eff_sw) begin
                rdata_d = '0;
            end else if (in_range(eff_addr)) begin
                rdata_d = eff_we ? eff_wdata : mem[eff_idx];
            end else begin
                rdata_d = '0;
            end
        end else if (sw_read) begin
            // Freeze the switch value shown during RESP so rdata holds it afterwards.
            rdata_d = sw_in;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && eff_we && in_range(eff_addr) && !eff_led && !eff_sw)
            mem[eff_idx] <= eff_wdata;
    end

    always_comb begin
        ack       = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
        err       = ack && !in_range(addr_q) && !q_led && !q_sw;
        rdata     = sw_read ? sw_in : rdata_q;
        led_out   = led_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder (LATENCY=2 instance) plus a LATENCY=0 instance
// exercised with directed back-to-back reads.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int W   = 16;
  localparam int AB  = 10;
  localparam int LAT = 2;

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
    int           at;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (LATENCY = 2)
  logic         req = 1'b0, we = 1'b0;
  logic [W-1:0] addr = '0, wdata = '0, sw = 16'h0A5A;
  logic [W-1:0] rdata, led_out;
  logic         ack, busy, err;
  logic [1:0]   st;

  mem_responder #(.WIDTH(W), .ADDRBITS(AB), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err), .sw_in(sw), .led_out(led_out),
    .state_dbg(st)
  );

  // second DUT (LATENCY = 0)
  logic         req0 = 1'b0, we0 = 1'b0;
  logic [W-1:0] addr0 = '0, wdata0 = '0;
  logic [W-1:0] rdata0, led0;
  logic         ack0, busy0, err0;
  logic [1:0]   st0;

  mem_responder #(.WIDTH(W), .ADDRBITS(AB), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0), .sw_in(sw), .led_out(led0),
    .state_dbg(st0)
  );

  // scoreboard state and reference model
  int           checks = 0;
  int           errors = 0;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] ref_mem [int];
  int           wr_list[$];
  logic [W-1:0] led_m = '0;
  int           busy_lo = -100, busy_hi = -100;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic w, input logic [W-1:0] a, input logic [W-1:0] d,
                                 input int at);
    exp_t e;
    e.at = at;
    e.err = 1'b0;
    e.rdata = '0;
`ifdef MEM_RESPONDER_MMIO_EN
    if (a == 16'hFFF0) begin
      if (w) led_m = d;
      e.rdata = led_m;
      return e;
    end
    if (a == 16'hFFF1) begin
      e.rdata = w ? '0 : sw;
      return e;
    end
`endif
    if (int'(a) < (1 << AB)) begin
      if (w) begin
        if (!ref_mem.exists(int'(a))) wr_list.push_back(int'(a));
        ref_mem[int'(a)] = d;
        e.rdata = d;
      end else begin
        e.rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 'x;
      end
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      check("busy", busy, (cyc > busy_lo && cyc <= busy_hi));
      if (ack) begin
        check("ack_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("ack_cycle", cyc, mon_e.at);
          check("rdata", rdata, mon_e.rdata);
          check("err", err, mon_e.err);
        end
      end else begin
        check("err_without_ack", err, 0);
        if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
          check("missing_ack", ack, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic wait_ack(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < LAT + 6 && !seen; i++) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    check("ack_seen", seen, 1);
  endtask

  task automatic issue(input logic w, input logic [W-1:0] a, input logic [W-1:0] d,
                       input bit mutate);
    bit seen;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    exp_q.push_back(model(w, a, d, cyc + LAT + 1));
    busy_lo = cyc; busy_hi = cyc + LAT + 1;
    if (mutate) begin
      @(posedge clk); #1;
      addr = 16'h0009; we = ~w; wdata = 16'hDEAD;
    end
    wait_ack(seen);
    req = 1'b0;
  endtask

  task automatic issue_held(input logic [W-1:0] a);
    bit seen;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(model(1'b0, a, '0, cyc + LAT + 1));
    exp_q.push_back(model(1'b0, a, '0, cyc + 2 * LAT + 3));
    busy_lo = cyc; busy_hi = cyc + LAT + 1;
    wait_ack(seen);
    @(posedge clk); #1;
    busy_lo = cyc; busy_hi = cyc + LAT + 1;
    wait_ack(seen);
    req = 1'b0;
  endtask

  task automatic l0_write(input logic [W-1:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("l0_write_ack", ack0, 1);
    check("l0_write_rdata", rdata0, d);
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    int           k;
    logic         w;
    logic [W-1:0] a, d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_led", led_out, 0);
    check("rst_state", st, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(1'b1, 16'h0005, 16'h1234, 1'b0);
    issue(1'b1, 16'h0006, 16'hBEEF, 1'b0);
    issue(1'b0, 16'h0005, '0, 1'b0);
    issue(1'b0, 16'h0006, '0, 1'b0);
    issue(1'b1, 16'h0009, 16'h9999, 1'b0);
    issue_held(16'h0005);
    issue(1'b0, 16'h0005, '0, 1'b1);
    issue(1'b0, 16'h0009, '0, 1'b0);

    issue(1'b1, 16'h0000, 16'h0C0C, 1'b0);
    issue(1'b1, 16'h0400, 16'hAAAA, 1'b0);
    issue(1'b0, 16'h0400, '0, 1'b0);
    issue(1'b0, 16'h0000, '0, 1'b0);
    issue(1'b1, 16'h03FF, 16'h5A5A, 1'b0);
    issue(1'b0, 16'h03FF, '0, 1'b0);

    issue(1'b1, 16'hFFF0, 16'h00FF, 1'b0);
    check("led_after_write", led_out, led_m);
    issue(1'b0, 16'hFFF1, '0, 1'b0);
    issue(1'b0, 16'hFFF0, '0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      d = 16'($urandom_range(0, 16'hFFFF));
      if (k <= 3) begin
        w = 1'b1; a = 16'($urandom_range(0, (1 << AB) - 1));
      end else if (k <= 7) begin
        w = 1'b0; a = 16'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
      end else begin
        w = (k == 9); a = 16'($urandom_range(1 << AB, 16'hFFEF));
      end
      issue(w, a, d, 1'b0);
    end

    // reset in the middle of a write: nothing committed, no ack
    issue(1'b1, 16'h0007, 16'h1111, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 16'h0007; wdata = 16'h7777;
    busy_lo = cyc; busy_hi = cyc + 1;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("abort_busy_in_wait", busy, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_ack", ack, 0);
    check("abort_busy", busy, 0);
    check("abort_rdata", rdata, 0);
    check("abort_led", led_out, 0);
    check("abort_state", st, 0);
    led_m = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ack", ack, 0);
    end
    issue(1'b0, 16'h0007, '0, 1'b0);

    // LATENCY = 0: back-to-back reads
    l0_write(16'h0001, 16'h0101);
    l0_write(16'h0002, 16'h0202);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
    @(negedge clk);
    check("l0_ack_c0", ack0, 0);
    @(negedge clk);
    check("l0_ack_c1", ack0, 1);
    check("l0_rdata_c1", rdata0, 16'h0101);
    check("l0_err_c1", err0, 0);
    addr0 = 16'h0002;
    @(negedge clk);
    check("l0_ack_c2", ack0, 0);
    @(negedge clk);
    check("l0_ack_c3", ack0, 1);
    check("l0_rdata_c3", rdata0, 16'h0202);
    req0 = 1'b0;
    @(negedge clk);
    check("l0_ack_c4", ack0, 0);
    check("l0_led", led0, 0);

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("led_final", led_out, led_m);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
